// File: rtl/maze_move_tracker.sv
// Tracks the bot's absolute pose (row, column, heading) from explorer move commands, and keeps step/U-turn/dead-end odometry.
// Accepted moves show on the outputs one clk later; one move per cycle, no backpressure. EXITED/FAULT ignore moves until rst/clear.
module maze_move_tracker #(
  parameter int ROWS      = 9,
  parameter int COLS      = 9,
  parameter int START_ROW = 8,
  parameter int START_COL = 4,
  parameter int START_DIR = 0,
  parameter int EXIT_ROW  = 0,
  parameter int EXIT_COL  = 4,
  parameter int EXIT_DIR  = 0,
  parameter int STEP_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              move_valid,
  input  logic [2:0]        move,
  output logic [3:0]        row,
  output logic [3:0]        col,
  output logic [1:0]        heading,
  output logic [STEP_W-1:0] step_cnt,
  output logic [6:0]        uturn_cnt,
  output logic [6:0]        dead_cnt,
  output logic              exited,
  output logic              fault,
  output logic              busy
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [3:0] START_ROW_V = 4'(START_ROW);
  localparam logic [3:0] START_COL_V = 4'(START_COL);
  localparam logic [1:0] START_DIR_V = 2'(START_DIR);

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};
  localparam logic [6:0]        CNT7_MAX = 7'h7f;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EXITED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t             state;
  logic [CELLS-1:0]   visited;

  logic               code_trans;
  logic               code_uturn;
  logic               code_illegal;
  logic [1:0]         turn;
  logic [1:0]         nh;
  logic [3:0]         tgt_row;
  logic [3:0]         tgt_col;
  logic               oob;
  logic               at_exit;
  logic               record_uturn;
  logic [IDX_W-1:0]   cell_idx;

  // Move decode: heading offset per code, 000 is a pure no-op.
  always_comb begin
    code_trans   = 1'b0;
    code_uturn   = 1'b0;
    code_illegal = 1'b0;
    turn         = 2'd0;
    case (move)
      3'b000: ;
      3'b001: begin code_trans = 1'b1; turn = 2'd0; end
      3'b010: begin code_trans = 1'b1; turn = 2'd3; end
      3'b011: begin code_trans = 1'b1; turn = 2'd1; end
      3'b100: begin code_trans = 1'b1; turn = 2'd2; code_uturn = 1'b1; end
      default: code_illegal = 1'b1;
    endcase
  end

  assign nh = heading + turn;

  // Target cell and grid-bound check; a wrap below 0 counts as out of bounds.
  always_comb begin
    tgt_row = row;
    tgt_col = col;
    oob     = 1'b0;
    case (nh)
      DIR_N: begin
        if (row == 4'd0) oob = 1'b1;
        else             tgt_row = row - 4'd1;
      end
      DIR_E: begin
        if (int'(col) + 1 >= COLS) oob = 1'b1;
        else                       tgt_col = col + 4'd1;
      end
      DIR_S: begin
        if (int'(row) + 1 >= ROWS) oob = 1'b1;
        else                       tgt_row = row + 4'd1;
      end
      DIR_W: begin
        if (col == 4'd0) oob = 1'b1;
        else             tgt_col = col - 4'd1;
      end
      default: oob = 1'b1;
    endcase
  end

  assign at_exit = (int'(row) == EXIT_ROW) && (int'(col) == EXIT_COL) && (int'(nh) == EXIT_DIR);

  // The U-turn belongs to the pre-move cell; an exit move still records it, a faulting one does not.
  assign record_uturn = code_uturn && (at_exit || !oob);
  assign cell_idx     = IDX_W'(int'(row) * COLS + int'(col));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      row       <= START_ROW_V;
      col       <= START_COL_V;
      heading   <= START_DIR_V;
      step_cnt  <= '0;
      uturn_cnt <= '0;
      dead_cnt  <= '0;
      visited   <= '0;
      exited    <= 1'b0;
      fault     <= 1'b0;
      busy      <= 1'b1;
    end else if (clear) begin
      state     <= ST_RUN;
      row       <= START_ROW_V;
      col       <= START_COL_V;
      heading   <= START_DIR_V;
      step_cnt  <= '0;
      uturn_cnt <= '0;
      dead_cnt  <= '0;
      visited   <= '0;
      exited    <= 1'b0;
      fault     <= 1'b0;
      busy      <= 1'b1;
    end else if (state == ST_RUN && move_valid) begin
      if (code_illegal) begin
        state <= ST_FAULT;
        fault <= 1'b1;
        busy  <= 1'b0;
      end else if (code_trans) begin
        if (at_exit) begin
          // Leaving through the exit: heading turns, the pose cell stays put.
          state   <= ST_EXITED;
          exited  <= 1'b1;
          busy    <= 1'b0;
          heading <= nh;
          if (step_cnt != STEP_MAX) step_cnt <= step_cnt + STEP_W'(1);
        end else if (oob) begin
          state <= ST_FAULT;
          fault <= 1'b1;
          busy  <= 1'b0;
        end else begin
          row     <= tgt_row;
          col     <= tgt_col;
          heading <= nh;
          if (step_cnt != STEP_MAX) step_cnt <= step_cnt + STEP_W'(1);
        end

        if (record_uturn) begin
          if (uturn_cnt != CNT7_MAX) uturn_cnt <= uturn_cnt + 7'd1;
          if (!visited[cell_idx]) begin
            visited[cell_idx] <= 1'b1;
            if (dead_cnt != CNT7_MAX) dead_cnt <= dead_cnt + 7'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_maze_move_tracker.sv
// Directed bench for maze_move_tracker: default grid instance plus a START_ROW=1 instance for the exit path.
module tb_maze_move_tracker;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       move_valid;
  logic [2:0] move;

  logic [3:0] row, col, x_row, x_col;
  logic [1:0] heading, x_heading;
  logic [9:0] step_cnt, x_step_cnt;
  logic [6:0] uturn_cnt, dead_cnt, x_uturn_cnt, x_dead_cnt;
  logic       exited, fault, busy, x_exited, x_fault, x_busy;

  int n_cmp;
  int n_bad;

  logic [36:0] obs, x_obs, exp;

  maze_move_tracker dut (
    .clk(clk), .rst(rst), .clear(clear), .move_valid(move_valid), .move(move),
    .row(row), .col(col), .heading(heading), .step_cnt(step_cnt),
    .uturn_cnt(uturn_cnt), .dead_cnt(dead_cnt), .exited(exited), .fault(fault), .busy(busy)
  );

  maze_move_tracker #(.START_ROW(1)) dut_x (
    .clk(clk), .rst(rst), .clear(clear), .move_valid(move_valid), .move(move),
    .row(x_row), .col(x_col), .heading(x_heading), .step_cnt(x_step_cnt),
    .uturn_cnt(x_uturn_cnt), .dead_cnt(x_dead_cnt), .exited(x_exited), .fault(x_fault), .busy(x_busy)
  );

  // Packed view: row, col, heading, step, uturn, dead, exited, fault, busy.
  assign obs   = {row, col, heading, step_cnt, uturn_cnt, dead_cnt, exited, fault, busy};
  assign x_obs = {x_row, x_col, x_heading, x_step_cnt, x_uturn_cnt, x_dead_cnt, x_exited, x_fault, x_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic c, input logic v, input logic [2:0] m);
    @(negedge clk);
    clear      = c;
    move_valid = v;
    move       = m;
    @(posedge clk);
    #1;
    clear      = 1'b0;
    move_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; move_valid = 1'b0; move = 3'b000;
    #12;
    exp = {4'd8, 4'd4, 2'd0, 10'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL reset_state: got %h want %h", obs, exp); end
    n_cmp++;
    if (x_row !== 4'd1) begin n_bad++; $display("FAIL reset_x_row: got %0d want 1", x_row); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forward_turn();
    apply(1'b0, 1'b1, 3'b001);
    exp = {4'd7, 4'd4, 2'd0, 10'd1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL fwd_001: got %h want %h", obs, exp); end
    apply(1'b0, 1'b1, 3'b011);
    exp = {4'd7, 4'd5, 2'd1, 10'd2, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL right_011: got %h want %h", obs, exp); end
    apply(1'b0, 1'b1, 3'b000);
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL stay_000: got %h want %h", obs, exp); end
    apply(1'b0, 1'b0, 3'b111);
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL invalid_ignored: got %h want %h", obs, exp); end
  endtask

  task automatic test_uturn();
    apply(1'b0, 1'b1, 3'b100);
    exp = {4'd7, 4'd4, 2'd3, 10'd3, 7'd1, 7'd1, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL uturn_1: got %h want %h", obs, exp); end
    apply(1'b0, 1'b1, 3'b100);
    exp = {4'd7, 4'd5, 2'd1, 10'd4, 7'd2, 7'd2, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL uturn_2: got %h want %h", obs, exp); end
    apply(1'b0, 1'b1, 3'b100);
    exp = {4'd7, 4'd4, 2'd3, 10'd5, 7'd3, 7'd2, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL uturn_3_revisit: got %h want %h", obs, exp); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp = {4'd8, 4'd4, 2'd0, 10'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL async_reset: got %h want %h", obs, exp); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fault();
    apply(1'b0, 1'b1, 3'b100);
    exp = {4'd8, 4'd4, 2'd0, 10'd0, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL fault_oob: got %h want %h", obs, exp); end
    apply(1'b0, 1'b1, 3'b001);
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL fault_absorbing: got %h want %h", obs, exp); end
    apply(1'b1, 1'b0, 3'b000);
    apply(1'b0, 1'b1, 3'b101);
    exp = {4'd8, 4'd4, 2'd0, 10'd0, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL fault_code101: got %h want %h", obs, exp); end
  endtask

  task automatic test_exit();
    apply(1'b1, 1'b0, 3'b000);
    apply(1'b0, 1'b1, 3'b001);
    exp = {4'd0, 4'd4, 2'd0, 10'd1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (x_obs !== exp) begin n_bad++; $display("FAIL exit_approach: got %h want %h", x_obs, exp); end
    apply(1'b0, 1'b1, 3'b001);
    exp = {4'd0, 4'd4, 2'd0, 10'd2, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0};
    n_cmp++;
    if (x_obs !== exp) begin n_bad++; $display("FAIL exit_taken: got %h want %h", x_obs, exp); end
    apply(1'b0, 1'b1, 3'b011);
    n_cmp++;
    if (x_obs !== exp) begin n_bad++; $display("FAIL exit_absorbing: got %h want %h", x_obs, exp); end
  endtask

  task automatic test_clear_priority();
    apply(1'b1, 1'b0, 3'b000);
    apply(1'b0, 1'b1, 3'b001);
    apply(1'b0, 1'b1, 3'b100);
    apply(1'b0, 1'b1, 3'b100);
    exp = {4'd7, 4'd4, 2'd0, 10'd3, 7'd2, 7'd2, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL pre_clear: got %h want %h", obs, exp); end
    apply(1'b1, 1'b1, 3'b001);
    exp = {4'd8, 4'd4, 2'd0, 10'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL clear_over_move: got %h want %h", obs, exp); end
    // Same U-turn cell as before the clear must count as new.
    apply(1'b0, 1'b1, 3'b001);
    apply(1'b0, 1'b1, 3'b100);
    exp = {4'd8, 4'd4, 2'd2, 10'd2, 7'd1, 7'd1, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL bitmap_cleared: got %h want %h", obs, exp); end
  endtask

  task automatic test_step_saturation();
    apply(1'b1, 1'b0, 3'b000);
    apply(1'b0, 1'b1, 3'b001);
    // Clockwise loop (7,4)->(7,5)->(8,5)->(8,4)->(7,4) using right turns only.
    for (int i = 0; i < 1022; i++) apply(1'b0, 1'b1, 3'b011);
    n_cmp++;
    if (step_cnt !== 10'd1023) begin n_bad++; $display("FAIL step_at_1023: got %0d want 1023", step_cnt); end
    for (int i = 0; i < 77; i++) apply(1'b0, 1'b1, 3'b011);
    exp = {4'd8, 4'd4, 2'd3, 10'd1023, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL step_saturated: got %h want %h", obs, exp); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_forward_turn();
    test_uturn();
    test_async_reset();
    test_fault();
    test_exit();
    test_clear_priority();
    test_step_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
